// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone interconnect family.
package wb_pkg;

  localparam int unsigned MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Keep only the lowest set bit (x & -x).
  function automatic logic [MAX_SLAVES-1:0] onehot_first(input logic [MAX_SLAVES-1:0] hits);
    return hits & (~hits + MAX_SLAVES'(1));
  endfunction

  function automatic int unsigned sel_w(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wb_intercon_n_if.sv
// Bus bundle between one Wishbone master, the interconnect and NUM_SLAVES slaves.
interface wb_intercon_n_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  localparam int unsigned SW = sel_w(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0]            wbm_adr_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_i;
  logic [SW-1:0]                    wbm_sel_i;
  logic                             wbm_we_i;
  logic                             wbm_cyc_i;
  logic                             wbm_stb_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_o;
  logic                             wbm_ack_o;
  logic                             wbm_err_o;

  logic [ADDR_WIDTH-1:0]            wbs_adr_o;
  logic [DATA_WIDTH-1:0]            wbs_dat_o;
  logic [SW-1:0]                    wbs_sel_o;
  logic                             wbs_we_o;
  logic [NUM_SLAVES-1:0]            wbs_cyc_o;
  logic [NUM_SLAVES-1:0]            wbs_stb_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i;
  logic [NUM_SLAVES-1:0]            wbs_ack_i;
  logic [NUM_SLAVES-1:0]            wbs_err_i;

  modport intercon (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o
  );

  modport slave (
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Mask/base address decoder: lowest-index hit wins, miss when nothing matches.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned                         ADDR_WIDTH = 32,
  parameter int unsigned                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  miss_o
);

  logic [NUM_SLAVES-1:0] raw_hit;

  always_comb begin
    raw_hit = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      raw_hit[k] = (adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])
                   == SLAVE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign hit_o  = NUM_SLAVES'(onehot_first(MAX_SLAVES'(raw_hit)));
  assign miss_o = ~|raw_hit;

endmodule

// File: rtl/wb_intercon_n.sv
// Single-master shared-bus Wishbone interconnect with decode-miss, slave-error and watchdog error paths.
module wb_intercon_n
  import wb_pkg::*;
#(
  parameter int unsigned                      DATA_WIDTH = 32,
  parameter int unsigned                      ADDR_WIDTH = 32,
  parameter int unsigned                      NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int unsigned                      TIMEOUT    = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_intercon_n_if.intercon bus
);

  localparam int unsigned     WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  state_e                 state_q, state_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   miss;
  logic                   slv_ack, slv_err;
  logic                   ack_c, err_c;
  logic [DATA_WIDTH-1:0]  rdata;

  wb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr_i  (bus.wbm_adr_i),
    .hit_o  (hit),
    .miss_o (miss)
  );

  // sel_q is zero outside BUSY, so unselected or idle-time responses vanish here.
  assign slv_ack = |(sel_q & bus.wbs_ack_i);
  assign slv_err = |(sel_q & bus.wbs_err_i);

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      rdata = rdata | (bus.wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_q[k]}});
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    ack_c   = 1'b0;
    err_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          if (miss) begin
            state_d = ERR;
          end else begin
            sel_d   = hit;
            wd_d    = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        err_c = slv_err;
        ack_c = slv_ack & ~slv_err;
        if (slv_ack || slv_err) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (!bus.wbm_cyc_i) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          sel_d   = '0;
          state_d = ERR;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.wbs_adr_o = bus.wbm_adr_i;
  assign bus.wbs_dat_o = bus.wbm_dat_i;
  assign bus.wbs_sel_o = bus.wbm_sel_i;
  assign bus.wbs_we_o  = bus.wbm_we_i;
  assign bus.wbs_cyc_o = sel_q & {NUM_SLAVES{bus.wbm_cyc_i}};
  assign bus.wbs_stb_o = sel_q & {NUM_SLAVES{bus.wbm_stb_i}};
  assign bus.wbm_dat_o = rdata;
  assign bus.wbm_ack_o = ack_c;
  assign bus.wbm_err_o = err_c;

endmodule
